// File: rtl/vx_dispatch_arb.sv
// Round-robin dispatch arbiter: NUM_REQS issue slices share one registered
// execution-unit port, with grant locking across multi-beat packets.
module vx_dispatch_arb #(
  parameter int unsigned NUM_REQS      = 4,
  parameter int unsigned DATAW         = 64,
  parameter int unsigned PERF_CTR_BITS = 32,
  localparam int unsigned SELW         = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQS-1:0]           req_valid,
  input  logic [NUM_REQS*DATAW-1:0]     req_data,
  input  logic [NUM_REQS-1:0]           req_eop,
  output logic [NUM_REQS-1:0]           req_ready,
  output logic                          out_valid,
  output logic [DATAW-1:0]              out_data,
  output logic                          out_eop,
  output logic [SELW-1:0]               out_sel,
  input  logic                          out_ready,
  output logic                          lock_active,
  output logic [PERF_CTR_BITS-1:0]      perf_stalls
);

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} state_e;

  state_e                     state_q;
  logic [SELW-1:0]            rr_ptr_q, rr_ptr_d, owner_q;
  logic                       out_valid_q;
  logic [DATAW-1:0]           out_data_q;
  logic                       out_eop_q;
  logic [SELW-1:0]            out_sel_q;
  logic [PERF_CTR_BITS-1:0]   perf_q;

  logic [NUM_REQS-1:0]        hi_mask, masked_valid;
  logic [SELW-1:0]            rr_grant, grant;
  logic                       owner_valid, grant_valid;
  logic [DATAW-1:0]           grant_data;
  logic                       grant_eop;
  logic                       can_accept, fire;

  // Round-robin pick: lowest valid index at or above rr_ptr, else lowest valid overall.
  always_comb begin
    hi_mask      = ~((NUM_REQS'(1) << rr_ptr_q) - NUM_REQS'(1));
    masked_valid = req_valid & hi_mask;
    rr_grant     = '0;
    for (int i = int'(NUM_REQS) - 1; i >= 0; i--) begin
      if (req_valid[i]) rr_grant = SELW'(i);
    end
    for (int i = int'(NUM_REQS) - 1; i >= 0; i--) begin
      if (masked_valid[i]) rr_grant = SELW'(i);
    end
  end

  always_comb begin
    owner_valid = 1'b0;
    for (int i = 0; i < int'(NUM_REQS); i++) begin
      if (SELW'(i) == owner_q) owner_valid = req_valid[i];
    end
  end

  always_comb begin
    if (state_q == LOCKED) begin
      grant       = owner_q;
      grant_valid = owner_valid;
    end else begin
      grant       = rr_grant;
      grant_valid = |req_valid;
    end
  end

  always_comb begin
    grant_data = '0;
    grant_eop  = 1'b0;
    for (int i = 0; i < int'(NUM_REQS); i++) begin
      if (SELW'(i) == grant) begin
        grant_data = req_data[i*DATAW +: DATAW];
        grant_eop  = req_eop[i];
      end
    end
  end

  assign can_accept = !out_valid_q || out_ready;
  assign fire       = can_accept && grant_valid;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < int'(NUM_REQS); i++) begin
      req_ready[i] = fire && (SELW'(i) == grant);
    end
  end

  always_comb begin
    if (32'(grant) + 32'd1 >= NUM_REQS) rr_ptr_d = '0;
    else                                 rr_ptr_d = grant + SELW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= UNLOCKED;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_eop_q   <= 1'b0;
      out_sel_q   <= '0;
      perf_q      <= '0;
    end else begin
      if (fire) begin
        out_valid_q <= 1'b1;
        out_data_q  <= grant_data;
        out_eop_q   <= grant_eop;
        out_sel_q   <= grant;
        if (!grant_eop) begin
          state_q <= LOCKED;
          owner_q <= grant;
        end else begin
          state_q  <= UNLOCKED;
          rr_ptr_q <= rr_ptr_d;
        end
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
      // Stall counter saturates rather than wrapping.
      if ((|req_valid) && !fire && (perf_q != '1)) begin
        perf_q <= perf_q + PERF_CTR_BITS'(1);
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_eop     = out_eop_q;
  assign out_sel     = out_sel_q;
  assign lock_active = (state_q == LOCKED);
  assign perf_stalls = perf_q;

endmodule

// File: tb/tb_vx_dispatch_arb.sv
// Directed bench for vx_dispatch_arb: a 4-requester build and a 1-requester build.
module tb_vx_dispatch_arb;

  logic        clk = 1'b0;
  logic        reset;

  logic [3:0]  rv, re, rdy;
  logic [63:0] rd;
  logic        ord;
  logic        ov, oe, lock;
  logic [15:0] od;
  logic [1:0]  osel;
  logic [31:0] perf;

  logic        rv1, re1, rdy1, ord1;
  logic [15:0] rd1;
  logic        ov1, oe1, lock1;
  logic [15:0] od1;
  logic        osel1;
  logic [31:0] perf1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vx_dispatch_arb #(.NUM_REQS(4), .DATAW(16), .PERF_CTR_BITS(32)) u_dut4 (
    .clk(clk), .reset(reset),
    .req_valid(rv), .req_data(rd), .req_eop(re), .req_ready(rdy),
    .out_valid(ov), .out_data(od), .out_eop(oe), .out_sel(osel),
    .out_ready(ord), .lock_active(lock), .perf_stalls(perf)
  );

  vx_dispatch_arb #(.NUM_REQS(1), .DATAW(16), .PERF_CTR_BITS(32)) u_dut1 (
    .clk(clk), .reset(reset),
    .req_valid(rv1), .req_data(rd1), .req_eop(re1), .req_ready(rdy1),
    .out_valid(ov1), .out_data(od1), .out_eop(oe1), .out_sel(osel1),
    .out_ready(ord1), .lock_active(lock1), .perf_stalls(perf1)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lane(input int i, input logic v, input logic [15:0] d, input logic e);
    rv[i]          = v;
    rd[i*16 +: 16] = d;
    re[i]          = e;
  endtask

  initial begin
    logic [3:0] exp4;
    reset = 1'b1;
    rv = '0; re = '0; rd = '0; ord = 1'b1;
    rv1 = 1'b0; re1 = 1'b0; rd1 = '0; ord1 = 1'b1;
    tick();
    tick();
    chk("rst_valid", ov, 0);
    chk("rst_data", od, 0);
    chk("rst_eop", oe, 0);
    chk("rst_sel", osel, 0);
    chk("rst_lock", lock, 0);
    chk("rst_perf", perf, 0);
    chk("rst1_valid", ov1, 0);
    chk("rst1_lock", lock1, 0);
    reset = 1'b0;

    // Round-robin across all four slices with single-beat packets
    for (int i = 0; i < 4; i++) lane(i, 1'b1, 16'h1000 + 16'(i), 1'b1);
    for (int k = 0; k < 6; k++) begin
      exp4 = 4'b0001 << (k % 4);
      #1 chk("rr_ready", rdy, exp4);
      tick();
      chk("rr_valid", ov, 1);
      chk("rr_sel", osel, k % 4);
      chk("rr_data", od, 16'h1000 + 16'(k % 4));
    end
    rv = '0;
    #1 chk("idle_ready", rdy, 0);
    tick();
    chk("idle_valid", ov, 0);
    chk("idle_sel_hold", osel, 1);
    chk("rr_perf", perf, 0);

    // Lock: req0 three-beat packet while req1 waits (rr_ptr = 2)
    lane(1, 1'b1, 16'h2100, 1'b1);
    lane(0, 1'b1, 16'h2000, 1'b0);
    #1 chk("lk_ready0", rdy, 4'b0001);
    tick();
    chk("lk_sel0", osel, 0);
    chk("lk_data0", od, 16'h2000);
    chk("lk_eop0", oe, 0);
    chk("lk_lock0", lock, 1);
    lane(0, 1'b1, 16'h2001, 1'b0);
    #1 chk("lk_ready1", rdy, 4'b0001);
    tick();
    chk("lk_data1", od, 16'h2001);
    chk("lk_lock1", lock, 1);
    lane(0, 1'b1, 16'h2002, 1'b1);
    #1 chk("lk_ready2", rdy, 4'b0001);
    tick();
    chk("lk_data2", od, 16'h2002);
    chk("lk_eop2", oe, 1);
    chk("lk_lock2", lock, 0);
    lane(0, 1'b0, 16'h0, 1'b0);
    #1 chk("lk_ready3", rdy, 4'b0010);
    tick();
    chk("lk_sel3", osel, 1);
    chk("lk_data3", od, 16'h2100);
    rv = '0;
    tick();
    chk("lk_perf", perf, 0);

    // Backpressure on req2 (rr_ptr = 2)
    ord = 1'b0;
    lane(2, 1'b1, 16'h3000, 1'b1);
    #1 chk("bp_ready_first", rdy, 4'b0100);
    tick();
    chk("bp_valid_first", ov, 1);
    chk("bp_data_first", od, 16'h3000);
    chk("bp_sel_first", osel, 2);
    lane(2, 1'b1, 16'h3001, 1'b1);
    for (int k = 0; k < 4; k++) begin
      #1 chk("bp_ready_stall", rdy, 0);
      tick();
      chk("bp_valid_hold", ov, 1);
      chk("bp_data_hold", od, 16'h3000);
    end
    chk("bp_perf", perf, 4);
    ord = 1'b1;
    #1 chk("bp_ready_refill", rdy, 4'b0100);
    tick();
    chk("bp_valid_refill", ov, 1);
    chk("bp_data_refill", od, 16'h3001);
    rv = '0;
    tick();
    chk("bp_drain", ov, 0);

    // Owner bubble: req3 goes idle mid-packet while req0 waits (rr_ptr = 3)
    lane(3, 1'b1, 16'h4000, 1'b0);
    lane(0, 1'b1, 16'h4100, 1'b1);
    #1 chk("ob_ready0", rdy, 4'b1000);
    tick();
    chk("ob_sel0", osel, 3);
    chk("ob_data0", od, 16'h4000);
    chk("ob_lock0", lock, 1);
    lane(3, 1'b0, 16'h0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      #1 chk("ob_ready_bubble", rdy, 0);
      tick();
      chk("ob_valid_bubble", ov, 0);
      chk("ob_lock_bubble", lock, 1);
    end
    chk("ob_perf", perf, 6);
    lane(3, 1'b1, 16'h4001, 1'b1);
    #1 chk("ob_ready1", rdy, 4'b1000);
    tick();
    chk("ob_sel1", osel, 3);
    chk("ob_data1", od, 16'h4001);
    chk("ob_lock1", lock, 0);
    lane(3, 1'b0, 16'h0, 1'b0);
    #1 chk("ob_ready2", rdy, 4'b0001);
    tick();
    chk("ob_sel2", osel, 0);
    chk("ob_data2", od, 16'h4100);
    rv = '0;
    tick();

    // Reset mid-lock (rr_ptr = 1 before reset)
    lane(1, 1'b1, 16'h5000, 1'b0);
    lane(3, 1'b1, 16'h5300, 1'b1);
    #1 chk("rm_ready0", rdy, 4'b0010);
    tick();
    chk("rm_sel0", osel, 1);
    chk("rm_lock0", lock, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rm_lock", lock, 0);
    chk("rm_valid", ov, 0);
    chk("rm_data", od, 0);
    chk("rm_perf", perf, 0);
    lane(1, 1'b0, 16'h0, 1'b0);
    lane(0, 1'b1, 16'h5100, 1'b1);
    #1 chk("rm_ready1", rdy, 4'b0001);
    tick();
    chk("rm_sel1", osel, 0);
    chk("rm_data1", od, 16'h5100);
    rv = '0;
    tick();

    // Single-requester build: alternating eop
    rv1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      rd1 = 16'h6000 + 16'(k);
      re1 = 1'(k % 2);
      #1 chk("n1_ready", rdy1, 1);
      tick();
      chk("n1_valid", ov1, 1);
      chk("n1_sel", osel1, 0);
      chk("n1_data", od1, 16'h6000 + 16'(k));
      chk("n1_eop", oe1, k % 2);
      chk("n1_lock", lock1, (k % 2) == 0);
    end
    rv1 = 1'b0;
    tick();
    chk("n1_drain", ov1, 0);
    chk("n1_perf", perf1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vx_dispatch_arb.md
Name: vx_dispatch_arb

Overview:
Round-robin arbiter that shares one execution-unit dispatch port between NUM_REQS issue slices. Sits between the per-slice dispatch buffers and a shared functional unit, for example the vector unit. Supports multi-beat operations: once a requester's first beat is granted, the grant is locked to it until its end-of-packet beat. The output is a single registered pipeline stage with a full valid/ready handshake and a stall counter for perf.

Parameters:
NUM_REQS, 4, number of requesting issue slices (>=1)
DATAW, 64, payload width per beat
PERF_CTR_BITS, 32, stall counter width
SELW, derived = max(1, clog2(NUM_REQS)), grant index width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  NUM_REQS  per-requester beat valid
req_data  in  NUM_REQS x DATAW  per-requester beat payload
req_eop  in  NUM_REQS  1 = last beat of the requester's operation
req_ready  out  NUM_REQS  per-requester beat accepted (combinational)
out_valid  out  1  registered beat valid to the execution unit
out_data  out  DATAW  registered payload
out_eop  out  1  registered end-of-packet flag
out_sel  out  SELW  index of the requester that sourced the beat
out_ready  in  1  execution unit accepts the beat
lock_active  out  1  arbiter is locked to one requester mid-packet
perf_stalls  out  PERF_CTR_BITS  cycles with pending requests but no transfer

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- Reset values:
  - out_valid=0, out_data=0, out_eop=0, out_sel=0.
  - lock_active=0, perf_stalls=0.
  - Internal rr_ptr=0, owner=0, state=UNLOCKED.
- Capacity: can_accept = !out_valid || out_ready.
- State UNLOCKED grant:
  - Grant goes to the first i with req_valid[i]=1, searching i = rr_ptr, rr_ptr+1, ... mod NUM_REQS.
  - grant_valid = |req_valid.
- State LOCKED grant:
  - Grant = owner; grant_valid = req_valid[owner].
  - All other requesters see req_ready=0.
- req_ready[i] = can_accept && grant_valid && (grant==i). All other bits are 0.
- fire = can_accept && grant_valid.
- On fire:
  - out_valid<=1, out_data<=req_data[grant], out_eop<=req_eop[grant], out_sel<=grant.
  - If req_eop[grant]=0: state<=LOCKED, owner<=grant.
  - If req_eop[grant]=1: state<=UNLOCKED, rr_ptr<=(grant+1) mod NUM_REQS.
- No fire and out_ready=1: out_valid<=0. out_data, out_eop and out_sel hold their values.
- No fire and out_ready=0: output registers hold.
- lock_active = (state==LOCKED). It is registered and updates in the cycle after the first non-eop beat fires.
- Latency and throughput:
  - Request-to-output latency is 1 cycle.
  - Sustained throughput is 1 beat/cycle when out_ready=1.
  - A full output with out_ready=1 accepts a new beat in the same cycle (pass-through refill, no bubble).
- Boundary conditions:
  - Owner deasserts valid while LOCKED: the arbiter stays LOCKED, grants nobody and inserts bubbles. Other requesters stay starved until the owner's eop beat.
  - Single-beat packets (eop=1 on the first beat) never enter LOCKED; rr_ptr still advances.
  - rr_ptr wraps from NUM_REQS-1 to 0.
  - NUM_REQS=1: grant is always 0 and out_sel=0; locking logic is still honoured.
  - Reset mid-packet: the lock and any in-flight output are dropped. The requester must re-present the packet from its first beat.
- perf_stalls: increments by 1 each cycle where (|req_valid) && !fire. It saturates at all-ones.
- Payload and eop are passed through untouched. No beat is reordered, duplicated or dropped.

Test Plan:
- Round-robin: NUM_REQS=4, all req_valid=1 with eop=1, out_ready=1 from reset -> out_sel sequence 0,1,2,3,0,1; one beat per cycle after 1-cycle latency; perf_stalls=0.
- Lock: req0 sends 3 beats (eop on the 3rd) while req1 is continuously valid -> out_sel = 0,0,0,1; lock_active=1 during the two cycles after beats 1 and 2; req_ready[1]=0 until req0's eop fires.
- Backpressure: out_ready=0 for 5 cycles with req2 valid -> out_valid=1 and out_data held; req_ready=0; perf_stalls increases by 4 (the first cycle fires into the empty register); after out_ready=1, the next beat arrives with no bubble.
- Owner bubble: req3 sends a non-eop beat, deasserts valid for 2 cycles, then sends an eop beat; req0 is valid throughout -> no req0 beat appears until after req3's eop; out_valid shows 2 bubble cycles.
- Reset mid-lock: req1 first beat fires, reset is asserted for 1 cycle -> lock_active=0, out_valid=0, rr_ptr=0; the next grant goes to the lowest valid index.
- NUM_REQS=1 build: alternating eop=0/1 beats -> out_sel=0 always; lock_active toggles correctly; data matches the input order.
